// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front-end with a small prefetch FIFO. A fetch PC register
// (fpc) walks forward in PC_INC steps and requests instructions from memory
// whenever the queue has room. Each accepted word is stored together with the
// address it came from. The decoder sees the head entry first-word
// fall-through style. A jump flushes the queue and restarts fetching at the
// target.
//
// Ports
//   i_clk       : clock, all state updates on the rising edge
//   i_rst       : synchronous active-low reset
//   o_mem_req   : fetch request to instruction memory (registered state only)
//   o_mem_addr  : fetch address (the fetch PC register)
//   i_mem_ack   : memory accepted the request, i_mem_data valid this cycle
//   i_mem_data  : fetched instruction word
//   o_valid     : head entry available to the decoder
//   o_ir        : head instruction word
//   o_pc        : address of the head instruction
//   o_pc_inc    : o_pc + PC_INC (wraps modulo 2^XLEN)
//   i_ready     : decoder consumes the head entry this cycle
//   i_jump      : redirect fetch to i_jump_pc and flush the queue
//   i_jump_pc   : redirect target
//   o_count     : number of occupied queue entries
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      ILEN     = 16,
   parameter int unsigned      DEPTH    = 4,
   parameter int unsigned      PC_INC   = 2,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   output logic                       o_mem_req,
   output logic [XLEN-1:0]            o_mem_addr,
   input  logic                       i_mem_ack,
   input  logic [ILEN-1:0]            i_mem_data,
   output logic                       o_valid,
   output logic [ILEN-1:0]            o_ir,
   output logic [XLEN-1:0]            o_pc,
   output logic [XLEN-1:0]            o_pc_inc,
   input  logic                       i_ready,
   input  logic                       i_jump,
   input  logic [XLEN-1:0]            i_jump_pc,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [ILEN-1:0] ir_mem [DEPTH];
   logic [XLEN-1:0] pc_mem [DEPTH];

   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] fpc;
   logic            run;

   logic            push;
   logic            pop;

   // The request depends only on registered state so that no combinational
   // path exists from the memory handshake or the decoder back to memory.
   assign o_mem_req  = run && (count < CW'(DEPTH));
   assign o_mem_addr = fpc;

   assign o_valid  = (count != '0);
   assign o_count  = count;
   assign o_ir     = ir_mem[head];
   assign o_pc     = pc_mem[head];
   assign o_pc_inc = pc_mem[head] + XLEN'(PC_INC);

   // A jump overrides both handshakes: ack data in the same cycle is dropped
   // and a concurrent pop is absorbed by the flush.
   assign push = o_mem_req && i_mem_ack && !i_jump;
   assign pop  = o_valid && i_ready && !i_jump;

   // Storage needs no reset; it is only observed while the entry is valid.
   always_ff @(posedge i_clk) begin
      if (push) begin
         ir_mem[tail] <= i_mem_data;
         pc_mem[tail] <= fpc;
      end
   end

   // Control state: pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         fpc   <= RESET_PC;
         run   <= 1'b0;
      end else begin
         run <= 1'b1;
         if (i_jump) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            fpc   <= i_jump_pc;
         end else begin
            if (push) begin
               tail <= tail + AW'(1);
               fpc  <= fpc + XLEN'(PC_INC);
            end
            if (pop) begin
               head <= head + AW'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. A behavioural model (a queue of
// {ir, pc} records plus a fetch PC and a run flag) predicts every output each
// cycle. Directed sequences cover reset, fill, streaming, jump and address
// wrap; a randomized phase exercises backpressure, jumps and resets.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

   typedef struct {
      logic [15:0] ir;
      logic [31:0] pc;
   } entry_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ack;
   logic [15:0] i_mem_data;
   logic        o_valid;
   logic [15:0] o_ir;
   logic [31:0] o_pc;
   logic [31:0] o_pc_inc;
   logic        i_ready;
   logic        i_jump;
   logic [31:0] i_jump_pc;
   logic [2:0]  o_count;

   int          checks = 0;
   int          errors = 0;

   entry_t      mq[$];
   logic [31:0] m_fpc;
   logic        m_run;

   fetch_queue dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_mem_req  (o_mem_req),
      .o_mem_addr (o_mem_addr),
      .i_mem_ack  (i_mem_ack),
      .i_mem_data (i_mem_data),
      .o_valid    (o_valid),
      .o_ir       (o_ir),
      .o_pc       (o_pc),
      .o_pc_inc   (o_pc_inc),
      .i_ready    (i_ready),
      .i_jump     (i_jump),
      .i_jump_pc  (i_jump_pc),
      .o_count    (o_count)
   );

   // 10 ns clock
   always #5 i_clk = ~i_clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare every DUT output against what the model says this cycle
   task automatic checkModel();
      logic [31:0] exp_inc;
      checkOutput("valid", 64'(o_valid), 64'(mq.size() != 0));
      checkOutput("count", 64'(o_count), 64'(mq.size()));
      checkOutput("mem_req", 64'(o_mem_req), 64'(m_run && mq.size() < 4));
      checkOutput("mem_addr", 64'(o_mem_addr), 64'(m_fpc));
      checkOutput("count_le4", 64'(o_count <= 3'd4), 64'd1);
      if (mq.size() != 0) begin
         exp_inc = mq[0].pc + 32'd2;
         checkOutput("head_ir", 64'(o_ir), 64'(mq[0].ir));
         checkOutput("head_pc", 64'(o_pc), 64'(mq[0].pc));
         checkOutput("head_pc_inc", 64'(o_pc_inc), 64'(exp_inc));
      end
   endtask

   // Drive one cycle of inputs, check outputs against the model before the
   // edge, then advance the model by the rules of the queue.
   task automatic applyStimulus(input logic rst, input logic ack, input logic [15:0] data,
                                input logic ready, input logic jump, input logic [31:0] jpc);
      logic   req;
      entry_t e;
      i_rst      = rst;
      i_mem_ack  = ack;
      i_mem_data = data;
      i_ready    = ready;
      i_jump     = jump;
      i_jump_pc  = jpc;
      #1;
      checkModel();
      @(posedge i_clk);
      if (!rst) begin
         mq.delete();
         m_fpc = 32'h0;
         m_run = 1'b0;
      end else begin
         req = m_run && (mq.size() < 4);
         if (jump) begin
            mq.delete();
            m_fpc = jpc;
         end else begin
            if (mq.size() != 0 && ready) void'(mq.pop_front());
            if (req && ack) begin
               e.ir = data;
               e.pc = m_fpc;
               mq.push_back(e);
               m_fpc = m_fpc + 32'd2;
            end
         end
         m_run = 1'b1;
      end
      #1;
   endtask

   initial begin
      // First reset edge: outputs are undefined before it, so no checks yet
      i_rst = 1'b0; i_mem_ack = 1'b1; i_mem_data = '0; i_ready = 1'b0;
      i_jump = 1'b0; i_jump_pc = '0;
      mq.delete(); m_fpc = '0; m_run = 1'b0;
      @(posedge i_clk);
      #1;

      // Reset held with ack asserted
      applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_valid", 64'(o_valid), 64'd0);
      checkOutput("rst_count", 64'(o_count), 64'd0);
      checkOutput("rst_req", 64'(o_mem_req), 64'd0);
      checkOutput("rst_addr", 64'(o_mem_addr), 64'd0);
      // Release edge: request appears the next cycle
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("release_req", 64'(o_mem_req), 64'd1);

      // Fill four entries with the decoder stalled
      for (int n = 0; n < 4; n++)
         applyStimulus(1'b1, 1'b1, 16'hA000 + 16'(n), 1'b0, 1'b0, 32'h0);
      checkOutput("fill_count", 64'(o_count), 64'd4);
      checkOutput("fill_req", 64'(o_mem_req), 64'd0);
      checkOutput("fill_addr", 64'(o_mem_addr), 64'd8);
      checkOutput("fill_pc", 64'(o_pc), 64'd0);
      checkOutput("fill_ir", 64'(o_ir), 64'hA000);
      checkOutput("fill_pc_inc", 64'(o_pc_inc), 64'd2);
      // Ack while full must be ignored
      applyStimulus(1'b1, 1'b1, 16'hEEEE, 1'b0, 1'b0, 32'h0);
      checkOutput("full_ack_count", 64'(o_count), 64'd4);
      // Drain in order
      for (int n = 0; n < 4; n++) begin
         checkOutput("drain_pc", 64'(o_pc), 64'(2 * n));
         applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
      end

      // Streaming: one instruction per cycle, occupancy stays at one
      applyStimulus(1'b1, 1'b1, 16'hC000, 1'b1, 1'b0, 32'h0);
      for (int n = 1; n < 6; n++) begin
         checkOutput("stream_count", 64'(o_count), 64'd1);
         checkOutput("stream_pc", 64'(o_pc), 64'(8 + 2 * (n - 1)));
         applyStimulus(1'b1, 1'b1, 16'hC000 + 16'(n), 1'b1, 1'b0, 32'h0);
      end

      // Build up three entries, then jump with a concurrent ack
      applyStimulus(1'b1, 1'b1, 16'hC100, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 16'hC101, 1'b0, 1'b0, 32'h0);
      checkOutput("prejump_count", 64'(o_count), 64'd3);
      applyStimulus(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 32'h100);
      checkOutput("jump_count", 64'(o_count), 64'd0);
      checkOutput("jump_valid", 64'(o_valid), 64'd0);
      checkOutput("jump_addr", 64'(o_mem_addr), 64'h100);
      applyStimulus(1'b1, 1'b1, 16'hB000, 1'b0, 1'b0, 32'h0);
      checkOutput("jump_head_pc", 64'(o_pc), 64'h100);
      checkOutput("jump_head_ir", 64'(o_ir), 64'hB000);

      // Address wrap at the top of the address space
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      applyStimulus(1'b1, 1'b1, 16'hD000, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 16'hD001, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap_pc0", 64'(o_pc), 64'hFFFF_FFFE);
      checkOutput("wrap_inc0", 64'(o_pc_inc), 64'h0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_pc1", 64'(o_pc), 64'h0);
      checkOutput("wrap_ir1", 64'(o_ir), 64'hD001);

      // Randomized backpressure with occasional jumps and resets
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom_range(0, 199) != 0),
                       1'($urandom_range(0, 1)),
                       16'($urandom),
                       1'($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 39) == 0),
                       $urandom);
      end
      checkModel();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
